// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Contents: FSM state enum (FETCH = 0), opcode constants, ALUOp and
// ALUControl encodings, and the ResultSrc / ALUSrcA / ALUSrcB / ImmSrc codes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_t;

    localparam logic [2:0] AluCtlAdd = 3'b000;
    localparam logic [2:0] AluCtlSub = 3'b001;
    localparam logic [2:0] AluCtlAnd = 3'b010;
    localparam logic [2:0] AluCtlOr  = 3'b011;
    localparam logic [2:0] AluCtlSlt = 3'b101;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control and immediate-format decode.
// Ports:
//   i_op          opcode, i_funct3 instr[14:12], i_funct7b5 instr[30]
//   i_alu_op      add / sub / funct request from the FSM
//   o_alu_control ALU operation select
//   o_imm_src     immediate format select (I/S/B/J)
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  alu_op_t    i_alu_op,
    output logic [2:0] o_alu_control,
    output logic [1:0] o_imm_src
);

    always_comb begin
        o_alu_control = AluCtlAdd;
        case (i_alu_op)
            AluOpSub: o_alu_control = AluCtlSub;
            AluOpFunct: begin
                case (i_funct3)
                    // op[5] separates R-type (sub exists) from I-type (addi only)
                    3'b000:  o_alu_control = (i_op[5] & i_funct7b5) ? AluCtlSub : AluCtlAdd;
                    3'b010:  o_alu_control = AluCtlSlt;
                    3'b110:  o_alu_control = AluCtlOr;
                    3'b111:  o_alu_control = AluCtlAnd;
                    default: o_alu_control = AluCtlAdd;
                endcase
            end
            default: o_alu_control = AluCtlAdd;
        endcase
    end

    always_comb begin
        case (i_op)
            OpStore: o_imm_src = ImmS;
            OpBeq:   o_imm_src = ImmB;
            OpJal:   o_imm_src = ImmJ;
            default: o_imm_src = ImmI;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller: one registered state, combinational
// next-state and control outputs, ALU/immediate decode in alu_decoder.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   op, funct3, funct7b5, Zero, mem_ready   instruction fields and status
//   mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
//   ALUSrcA, ALUSrcB, ALUControl, ImmSrc    datapath controls
//   illegal  pulse in DECODE on unsupported opcode; state_o debug state
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t  r_state;
    state_t  w_state_d;
    alu_op_t w_alu_op;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_alu_op  = AluOpAdd;
        mem_req   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        illegal   = 1'b0;
        case (r_state)
            StFetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: w_state_d = StMemAdr;
                    OpRType:         w_state_d = StExecuteR;
                    OpIType:         w_state_d = StExecuteI;
                    OpJal:           w_state_d = StJal;
                    OpBeq:           w_state_d = StBeq;
                    default: begin
                        w_state_d = StFetch;
                        illegal   = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBImm;
                w_state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    w_state_d = StMemWb;
                end
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = 1'b1;
                w_state_d = StFetch;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    w_state_d = StFetch;
                end
            end
            StExecuteR: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBRs2;
                w_alu_op  = AluOpFunct;
                w_state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBImm;
                w_alu_op  = AluOpFunct;
                w_state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite  = 1'b1;
                w_state_d = StFetch;
            end
            StJal: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                PCWrite   = 1'b1;
                w_state_d = StAluWb;
            end
            StBeq: begin
                ALUSrcA   = SrcARs1;
                ALUSrcB   = SrcBRs2;
                w_alu_op  = AluOpSub;
                PCWrite   = Zero;
                w_state_d = StFetch;
            end
            default: w_state_d = StFetch;
        endcase

        // Reset is synchronous, so the state register may still hold a
        // mid-transaction state; suppress every side effect while it is held.
        if (!rst_n) begin
            w_state_d = StFetch;
            w_alu_op  = AluOpAdd;
            mem_req   = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = ResAluOut;
            ALUSrcA   = SrcAPc;
            ALUSrcB   = SrcBRs2;
            illegal   = 1'b0;
        end
    end

    assign state_o = rst_n ? r_state : StFetch;

    alu_decoder u_alu_decoder (
        .i_op          (op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_alu_op      (w_alu_op),
        .o_alu_control (ALUControl),
        .o_imm_src     (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency/decode table, directed
// multi-cycle corner cases, and randomized instructions against a phase model.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic       clk, rst_n, funct7b5, Zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {PhFetch, PhDecode, PhMemAdr, PhMemRead, PhMemWb, PhMemWrite,
                      PhExec, PhAluWb, PhJal, PhBeq} phase_t;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
        logic       illegal;
        logic       in_fetch;
    } ctl_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cycles;
        logic       chk_alu;
        logic [2:0] alu;
        logic [1:0] imm;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic sample_cycle(input logic mr);
        mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Arithmetic operation an R/I instruction asks for; only R-type has sub.
    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t exp_ctl(input phase_t ph, input logic mr, input logic z,
                                     input logic [6:0] o, input logic [2:0] f3, input logic f7);
        ctl_t c;
        c = '0;
        c.imm_src = imm_of(o);
        case (ph)
            PhFetch: begin
                c.in_fetch = 1'b1; c.mem_req = 1'b1; c.src_b = 2'b10;
                c.result_src = 2'b10; c.ir_write = mr; c.pc_write = mr;
            end
            PhDecode:   begin c.src_a = 2'b01; c.src_b = 2'b01; c.illegal = !is_legal(o); end
            PhMemAdr:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            PhMemRead:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            PhMemWb:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            PhMemWrite: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
            PhExec: begin
                c.src_a = 2'b10; c.src_b = (o == OP_R) ? 2'b00 : 2'b01;
                c.alu_ctrl = alu_fn(o, f3, f7);
            end
            PhAluWb:    c.reg_write = 1'b1;
            PhJal:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
            PhBeq:      begin c.src_a = 2'b10; c.alu_ctrl = 3'b001; c.pc_write = z; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t act_ctl();
        return {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, illegal, state_o == 4'd0};
    endfunction

    vec_t   vecs[11];
    phase_t plan[$];

    initial begin
        logic [6:0] lw_mr;
        logic [6:0] legal_ops[6];
        int         n;
        logic [2:0] alu_seen;
        logic [1:0] imm_seen;

        vecs[0]  = '{"r_add",   OP_R,   3'b000, 1'b0, 1'b0, 4, 1'b1, 3'b000, 2'b00};
        vecs[1]  = '{"r_sub",   OP_R,   3'b000, 1'b1, 1'b0, 4, 1'b1, 3'b001, 2'b00};
        vecs[2]  = '{"r_and",   OP_R,   3'b111, 1'b0, 1'b0, 4, 1'b1, 3'b010, 2'b00};
        vecs[3]  = '{"r_or",    OP_R,   3'b110, 1'b0, 1'b0, 4, 1'b1, 3'b011, 2'b00};
        vecs[4]  = '{"i_slti",  OP_I,   3'b010, 1'b0, 1'b0, 4, 1'b1, 3'b101, 2'b00};
        vecs[5]  = '{"i_addi7", OP_I,   3'b000, 1'b1, 1'b0, 4, 1'b1, 3'b000, 2'b00};
        vecs[6]  = '{"lw",      OP_LW,  3'b010, 1'b0, 1'b0, 5, 1'b1, 3'b000, 2'b00};
        vecs[7]  = '{"sw",      OP_SW,  3'b010, 1'b0, 1'b0, 4, 1'b1, 3'b000, 2'b01};
        vecs[8]  = '{"beq",     OP_BEQ, 3'b000, 1'b0, 1'b1, 3, 1'b1, 3'b001, 2'b10};
        vecs[9]  = '{"jal",     OP_JAL, 3'b000, 1'b0, 1'b0, 4, 1'b1, 3'b000, 2'b11};
        vecs[10] = '{"illegal", 7'h00,  3'b000, 1'b0, 1'b0, 2, 1'b0, 3'b000, 2'b00};

        // Reset with inputs that would otherwise request a fetch.
        rst_n = 1'b0; op = OP_LW; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        repeat (3) next_cycle();
        sample_cycle(1'b1);
        check("reset_outputs", {mem_req, IRWrite, PCWrite, MemWrite, RegWrite, illegal, state_o},
              '0);
        next_cycle();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        next_cycle();

        // Latency / decode table with mem_ready held high.
        foreach (vecs[i]) begin
            op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; Zero = vecs[i].z;
            n = 0; alu_seen = 3'bxxx; imm_seen = 2'bxx;
            while (n < 20) begin
                sample_cycle(1'b1);
                if (n > 0 && state_o == 4'd0) break;
                if (n == 0) imm_seen = ImmSrc;
                if (n == 2) alu_seen = ALUControl;
                n++;
                next_cycle();
            end
            check({vecs[i].name, "_latency"}, n, vecs[i].cycles);
            check({vecs[i].name, "_immsrc"}, imm_seen, vecs[i].imm);
            if (vecs[i].chk_alu) check({vecs[i].name, "_aluctl"}, alu_seen, vecs[i].alu);
            mem_ready = 1'b0;
            next_cycle();
        end

        // R-type sub: RegWrite only in the fourth cycle, sub in EXECUTER.
        op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1; Zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_cycle(1'b1);
            check("rsub_regwrite", RegWrite, (i == 3));
            if (i == 2) check("rsub_aluctl", ALUControl, 3'b001);
            next_cycle();
        end
        sample_cycle(1'b0);
        check("rsub_back_fetch", state_o, 4'd0);
        next_cycle();

        // lw with two stalled MEMREAD cycles: 7 cycles total.
        op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0;
        lw_mr = 7'b1100111;
        for (int i = 0; i < 7; i++) begin
            sample_cycle(lw_mr[i]);
            if (i >= 3 && i <= 5) check("lw_memread_req", {mem_req, AdrSrc}, 2'b11);
            if (i == 6) begin
                check("lw_memwb", {ResultSrc, RegWrite}, 3'b011);
                check("lw_memwb_not_fetch", state_o != 4'd0, 1'b1);
            end
            next_cycle();
        end
        sample_cycle(1'b0);
        check("lw_7_cycles", state_o, 4'd0);
        next_cycle();

        // beq taken and not taken.
        for (int z = 1; z >= 0; z--) begin
            op = OP_BEQ; Zero = z[0];
            sample_cycle(1'b1); next_cycle();
            sample_cycle(1'b1); next_cycle();
            sample_cycle(1'b1);
            check("beq_pcwrite", PCWrite, z[0]);
            check("beq_aluctl", ALUControl, 3'b001);
            next_cycle();
            sample_cycle(1'b0);
            check("beq_back_fetch", state_o, 4'd0);
            next_cycle();
        end

        // Unsupported opcode: one-cycle illegal pulse in DECODE, no writes.
        op = 7'h00; Zero = 1'b0;
        sample_cycle(1'b1);
        check("illegal_in_fetch", illegal, 1'b0);
        next_cycle();
        sample_cycle(1'b1);
        check("illegal_decode", {illegal, PCWrite, IRWrite, MemWrite, RegWrite}, 5'b10000);
        next_cycle();
        sample_cycle(1'b0);
        check("illegal_after", {illegal, state_o}, 5'b0);
        next_cycle();

        // Fetch stalled three cycles, then a single IRWrite/PCWrite cycle.
        op = OP_R; funct3 = 3'b111; funct7b5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_cycle(1'b0);
            check("fetch_stall_we", {IRWrite, PCWrite}, 2'b00);
            next_cycle();
        end
        sample_cycle(1'b1);
        check("fetch_done_we", {IRWrite, PCWrite}, 2'b11);
        next_cycle();
        sample_cycle(1'b1);
        check("fetch_once_we", {IRWrite, PCWrite, state_o != 4'd0}, 3'b001);
        next_cycle();
        sample_cycle(1'b1); next_cycle();
        sample_cycle(1'b1); next_cycle();

        // Reset during a stalled MEMWRITE.
        op = OP_SW; funct3 = 3'b010;
        sample_cycle(1'b1); next_cycle();
        sample_cycle(1'b1); next_cycle();
        sample_cycle(1'b1); next_cycle();
        sample_cycle(1'b0);
        check("sw_memwrite_held", MemWrite, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        sample_cycle(1'b0);
        check("sw_reset_gates", {MemWrite, mem_req, state_o}, 6'b0);
        next_cycle();
        rst_n = 1'b1;
        sample_cycle(1'b0);
        check("sw_reset_to_fetch", {state_o, MemWrite, mem_req}, 6'b000001);
        next_cycle();

        // Randomized instructions against the phase model.
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
        for (int k = 0; k < 300; k++) begin
            int sel;
            sel = $urandom_range(0, 7);
            op = (sel < 6) ? legal_ops[sel] : 7'($urandom_range(0, 127));
            funct3 = 3'($urandom_range(0, 7));
            funct7b5 = 1'($urandom_range(0, 1));
            plan.delete();
            plan.push_back(PhFetch);
            plan.push_back(PhDecode);
            if (op == OP_LW) begin
                plan.push_back(PhMemAdr); plan.push_back(PhMemRead); plan.push_back(PhMemWb);
            end else if (op == OP_SW) begin
                plan.push_back(PhMemAdr); plan.push_back(PhMemWrite);
            end else if (op == OP_R || op == OP_I) begin
                plan.push_back(PhExec); plan.push_back(PhAluWb);
            end else if (op == OP_JAL) begin
                plan.push_back(PhJal); plan.push_back(PhAluWb);
            end else if (op == OP_BEQ) begin
                plan.push_back(PhBeq);
            end
            foreach (plan[p]) begin
                int   waits;
                logic mr;
                waits = 0;
                do begin
                    mr = (waits >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    Zero = 1'($urandom_range(0, 1));
                    sample_cycle(mr);
                    check("rand_ctl", 32'(act_ctl()),
                          32'(exp_ctl(plan[p], mr, Zero, op, funct3, funct7b5)));
                    next_cycle();
                    waits++;
                end while ((plan[p] inside {PhFetch, PhMemRead, PhMemWrite}) && !mr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters. One clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 op  in  7  opcode of the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completes the access this cycle.
REQ-009 mem_req  out  1  memory access request.
REQ-010 AdrSrc  out  1  0 = PC, 1 = ALU result as memory address.
REQ-011 IRWrite, PCWrite, MemWrite, RegWrite  out  1 each  write enables.
REQ-012 ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-015 ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-016 ImmSrc  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type.
REQ-017 illegal  out  1  one-cycle pulse on an unsupported opcode.
REQ-018 state_o  out  4  current state encoding, for debug.

Function
REQ-019 The block SHALL be an FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ. All outputs not listed for a state SHALL be 0.
REQ-020 FETCH SHALL drive mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add and ResultSrc=10.
- If mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
- Otherwise: IRWrite=0, PCWrite=0, remain in FETCH.
REQ-021 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01 and ALUOp=add. Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other op -> FETCH, with illegal=1 for this cycle.
REQ-022 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOp=add. Next state is MEMREAD if op=0000011, else MEMWRITE.
REQ-023 MEMREAD SHALL drive mem_req=1, AdrSrc=1 and ResultSrc=00. It SHALL stay until mem_ready=1, then go to MEMWB.
REQ-024 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive mem_req=1, AdrSrc=1, ResultSrc=00, and MemWrite=1 held until mem_ready=1, then go to FETCH.
REQ-026 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00 and ALUOp=funct, then go to ALUWB.
REQ-027 EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01 and ALUOp=funct, then go to ALUWB.
REQ-028 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-029 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-030 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00 and PCWrite=Zero, then go to FETCH.
REQ-031 ALU decode SHALL be combinational:
- ALUOp add -> 000; ALUOp sub -> 001.
- ALUOp funct, by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; others -> 000.
REQ-032 ImmSrc SHALL be combinational from op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-033 Only FETCH, MEMREAD and MEMWRITE SHALL wait on mem_ready; every other state SHALL last exactly one cycle.
REQ-034 Instruction latency with mem_ready=1:
- R, I, jal: 4 cycles.
- beq: 3 cycles.
- sw: 4 cycles.
- lw: 5 cycles.
- Each extra cycle with mem_ready=0 in a waiting state adds 1 cycle.

Reset
REQ-035 rst_n=0 at a clock edge SHALL place the FSM in FETCH from any state, including a mid-transaction wait.
REQ-036 While rst_n=0: PCWrite, IRWrite, MemWrite, RegWrite, mem_req and illegal SHALL be 0, and state_o SHALL be 0 (FETCH encoding).

Structure
REQ-037 Package rv_ctrl_pkg SHALL hold:
- the state enum (4-bit, FETCH=0)
- opcode constants
- ALUOp and ALUControl encodings
- ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-038 The ALU and ImmSrc decode SHALL be a sub-module alu_decoder. The FSM SHALL be a single registered state with combinational next-state and output logic.

Verification
REQ-039 op=0110011, funct3=000, funct7b5=1, mem_ready=1:
- Sequence FETCH->DECODE->EXECUTER->ALUWB->FETCH.
- ALUControl=001 in EXECUTER.
- RegWrite=1 only in ALUWB.
REQ-040 op=0000011 with mem_ready=0 for 2 cycles in MEMREAD:
- 7 cycles total.
- mem_req=1 and AdrSrc=1 throughout MEMREAD.
- ResultSrc=01 and RegWrite=1 in MEMWB.
REQ-041 op=1100011:
- Zero=1 -> PCWrite=1 and ALUControl=001 in BEQ.
- Zero=0 -> PCWrite=0.
- Both cases return to FETCH.
REQ-042 op=0000000 -> illegal=1 for one cycle in DECODE, next state FETCH, no write enable asserted.
REQ-043 rst_n=0 while in MEMWRITE with mem_ready=0 -> next cycle state_o=0 and MemWrite=0.
REQ-044 FETCH with mem_ready=0 for 3 cycles -> IRWrite=0 and PCWrite=0 for those cycles, then exactly one cycle of IRWrite=1 and PCWrite=1.
